// File: rtl/fibonacci_sweeper.sv
// Fibonacci sweeper: drives one Fibonacci calculator across an index range and
// stores each result in a table with a registered read port and valid bits.
// Flags calculator timeouts, range errors and 16-bit overflow (result decrease).
module fibonacci_sweeper #(
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  first_idx,
    input  logic [IDX_W-1:0]  last_idx,
    output logic              calc_reset_n,
    output logic [IDX_W-1:0]  calc_input_s,
    output logic              calc_begin,
    input  logic              calc_done,
    input  logic [DATA_W-1:0] calc_fibo_out,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              sweep_done,
    output logic              err_timeout,
    output logic              err_ovf,
    output logic              err_range
);

    localparam int unsigned DEPTH     = 1 << IDX_W;
    localparam logic [7:0]  WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_STORE,
        S_FINISH
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [IDX_W-1:0]    first_q;
    logic [IDX_W-1:0]    last_q;
    logic [IDX_W-1:0]    cur_idx;
    logic [7:0]          wait_cnt;
    logic [DATA_W-1:0]   result_q;
    logic [DATA_W-1:0]   prev_value;
    logic [DEPTH-1:0]    valid_q;
    logic [DATA_W-1:0]   table_mem [DEPTH];
    logic                done_ok;
    logic                wait_expired;

    // done is ignored in the first WAIT cycle while the calculator settles
    assign done_ok      = calc_done && (wait_cnt != 8'd0);
    assign wait_expired = (wait_cnt == WAIT_LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = (first_idx > last_idx) ? S_FINISH : S_CLEAR;
                end
            end
            S_CLEAR:  state_nx = S_LAUNCH;
            S_LAUNCH: state_nx = S_WAIT;
            S_WAIT: begin
                if (done_ok) begin
                    state_nx = S_STORE;
                end else if (wait_expired) begin
                    state_nx = S_FINISH;
                end
            end
            S_STORE:  state_nx = (cur_idx == last_q) ? S_FINISH : S_CLEAR;
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state; calculator reset also follows the block reset
    always_comb begin
        busy         = (state != S_IDLE);
        calc_begin   = (state == S_LAUNCH);
        calc_reset_n = reset_n && (state != S_CLEAR);
        calc_input_s = cur_idx;
    end

    // Sweep datapath: index, wait counter, captured result, flags, valid bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            first_q     <= '0;
            last_q      <= '0;
            cur_idx     <= '0;
            wait_cnt    <= '0;
            result_q    <= '0;
            prev_value  <= '0;
            valid_q     <= '0;
            sweep_done  <= 1'b0;
            err_timeout <= 1'b0;
            err_ovf     <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            sweep_done <= (state == S_FINISH);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_timeout <= 1'b0;
                        err_ovf     <= 1'b0;
                        err_range   <= 1'b0;
                        first_q     <= first_idx;
                        last_q      <= last_idx;
                        valid_q     <= '0;
                        if (first_idx > last_idx) begin
                            err_range <= 1'b1;
                        end else begin
                            cur_idx <= first_idx;
                        end
                    end
                end
                S_LAUNCH: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (done_ok) begin
                        result_q <= calc_fibo_out;
                    end else if (wait_expired) begin
                        err_timeout <= 1'b1;
                    end
                end
                S_STORE: begin
                    valid_q[cur_idx] <= 1'b1;
                    if ((cur_idx > first_q) && (result_q < prev_value)) begin
                        err_ovf <= 1'b1;
                    end
                    prev_value <= result_q;
                    // equality stop means last_idx at the top index never wraps
                    if (cur_idx != last_q) begin
                        cur_idx <= cur_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result table storage (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (state == S_STORE) begin
            table_mem[cur_idx] <= result_q;
        end
    end

    // Registered read port; a same-cycle write returns the old entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_data  <= table_mem[rd_addr];
            rd_valid <= valid_q[rd_addr];
        end
    end

endmodule

// File: tb/tb_fibonacci_sweeper.sv
// Self-checking bench for fibonacci_sweeper: behavioural calculator with random
// latency, sweep-level reference model checked every cycle, directed literal checks.
module tb_fibonacci_sweeper;

    localparam int unsigned IDX_W   = 5;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned TIMEOUT = 63;
    localparam int unsigned DEPTH   = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [IDX_W-1:0]  first_idx = '0;
    logic [IDX_W-1:0]  last_idx = '0;
    logic              calc_reset_n;
    logic [IDX_W-1:0]  calc_input_s;
    logic              calc_begin;
    logic              calc_done = 1'b0;
    logic [DATA_W-1:0] calc_fibo_out = '0;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              sweep_done;
    logic              err_timeout;
    logic              err_ovf;
    logic              err_range;

    logic              rd_manual = 1'b0;
    logic [IDX_W-1:0]  rd_addr_man = '0;
    logic [IDX_W-1:0]  rd_addr_rand = '0;
    logic              calc_hang = 1'b0;

    int unsigned total = 0;
    int unsigned bad = 0;

    assign rd_addr = rd_manual ? rd_addr_man : rd_addr_rand;

    fibonacci_sweeper #(.IDX_W(IDX_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .first_idx(first_idx), .last_idx(last_idx),
        .calc_reset_n(calc_reset_n), .calc_input_s(calc_input_s), .calc_begin(calc_begin),
        .calc_done(calc_done), .calc_fibo_out(calc_fibo_out),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .sweep_done(sweep_done),
        .err_timeout(err_timeout), .err_ovf(err_ovf), .err_range(err_range)
    );

    always #5 clk = ~clk;

    function automatic int unsigned fib(input int unsigned n);
        int unsigned a = 0;
        int unsigned b = 1;
        int unsigned t;
        for (int unsigned i = 0; i < n; i++) begin
            t = (a + b) & 32'hFFFF;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic void chk(input string nm, input int unsigned got, input int unsigned exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endfunction

    // Reference model state
    bit          m_busy = 0;
    bit          m_hang = 0;
    int unsigned m_cycles, m_exp_len, m_begins, m_clears;
    int unsigned m_first, m_last, m_next;
    int unsigned idle_cnt = 0;
    int unsigned prev_addr = 0;
    bit          prev_manual = 1;
    bit          exp_valid [DEPTH];
    int unsigned exp_data [DEPTH];
    bit          m_err_t = 0, m_err_o = 0, m_err_r = 0;
    bit          c_run = 0;
    int unsigned c_cnt = 0, c_lat = 0;

    // Calculator model and per-cycle comparison against the sweep model
    always @(negedge clk) begin
        int unsigned nexp;
        if (!reset_n) begin
            m_busy = 0;
            m_err_t = 0; m_err_o = 0; m_err_r = 0;
            for (int i = 0; i < DEPTH; i++) exp_valid[i] = 0;
            idle_cnt = 0;
            c_run = 0;
            calc_done = 1'b0;
            calc_fibo_out = '0;
        end else begin
            if (!calc_reset_n) begin
                c_run = 0;
                m_clears++;
            end else if (calc_begin) begin
                chk("begin_index", calc_input_s, m_next);
                m_next++;
                c_run = 1;
                c_cnt = 0;
                c_lat = $urandom_range(0, 6);
                m_begins++;
                m_exp_len += calc_hang ? (2 + TIMEOUT) : (((c_lat < 2) ? 2 : c_lat) + 3);
            end else if (c_run) begin
                c_cnt++;
            end
            calc_done     = c_run && !calc_hang && (c_cnt >= c_lat);
            calc_fibo_out = calc_done ? DATA_W'(fib(calc_input_s)) : '0;

            if (m_busy) begin
                if (busy) begin
                    m_cycles++;
                    if (m_cycles > 4000) begin
                        chk("sweep_length_bound", m_cycles, m_exp_len);
                        m_busy = 0;
                    end
                end else begin
                    chk("sweep_done_pulse", sweep_done, 1);
                    chk("sweep_cycles", m_cycles, m_exp_len);
                    if (m_first > m_last) nexp = 0;
                    else if (m_hang) nexp = 1;
                    else nexp = m_last - m_first + 1;
                    chk("calc_begin_count", m_begins, nexp);
                    chk("calc_clear_count", m_clears, nexp);
                    if (m_first > m_last) begin
                        m_err_r = 1;
                    end else if (m_hang) begin
                        m_err_t = 1;
                    end else begin
                        for (int unsigned i = m_first; i <= m_last; i++) begin
                            exp_valid[i] = 1;
                            exp_data[i]  = fib(i);
                            if (i > m_first && fib(i) < fib(i - 1)) m_err_o = 1;
                        end
                    end
                    m_busy = 0;
                    idle_cnt = 0;
                end
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_sweep_done", sweep_done, 0);
                chk("idle_calc_begin", calc_begin, 0);
                chk("idle_calc_reset_n", calc_reset_n, 1);
                chk("err_timeout", err_timeout, m_err_t);
                chk("err_ovf", err_ovf, m_err_o);
                chk("err_range", err_range, m_err_r);
                if (idle_cnt >= 2 && !rd_manual && !prev_manual) begin
                    chk("rd_valid", rd_valid, exp_valid[prev_addr]);
                    if (exp_valid[prev_addr]) chk("rd_data", rd_data, exp_data[prev_addr]);
                end
                idle_cnt++;
                if (start) begin
                    m_busy = 1;
                    m_first = first_idx;
                    m_last = last_idx;
                    m_next = first_idx;
                    m_hang = calc_hang;
                    m_exp_len = 1;
                    m_cycles = 0;
                    m_begins = 0;
                    m_clears = 0;
                    m_err_t = 0; m_err_o = 0; m_err_r = 0;
                    for (int i = 0; i < DEPTH; i++) exp_valid[i] = 0;
                end
            end
        end
        prev_manual  = rd_manual;
        rd_addr_rand = IDX_W'($urandom);
        prev_addr    = rd_addr_rand;
    end

    task automatic run_sweep(input int unsigned f, input int unsigned l, input bit hang,
                             input bit extra, input string nm);
        bit ok;
        @(posedge clk); #1;
        first_idx = IDX_W'(f);
        last_idx  = IDX_W'(l);
        calc_hang = hang;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (extra && f <= l) begin
            repeat (2) @(posedge clk);
            #1;
            first_idx = '0;
            last_idx  = '1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (sweep_done) begin
                ok = 1;
                break;
            end
        end
        chk({nm, "_completes"}, ok, 1);
        @(posedge clk); #1;
        calc_hang = 1'b0;
    endtask

    task automatic rd_chk(input int unsigned a, input bit v, input int unsigned d,
                          input string nm);
        rd_manual = 1'b1;
        @(posedge clk); #1;
        rd_addr_man = IDX_W'(a);
        @(posedge clk); #1;
        chk({nm, "_valid"}, rd_valid, v);
        if (v) chk({nm, "_data"}, rd_data, d);
        rd_manual = 1'b0;
    endtask

    initial begin
        int unsigned f1 [10] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
        int unsigned f, l;
        bit ok;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_calc_reset_n", calc_reset_n, 0);
        chk("rst_calc_begin", calc_begin, 0);
        chk("rst_calc_input_s", calc_input_s, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_sweep_done", sweep_done, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_range", err_range, 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Sweep 1..10
        run_sweep(1, 10, 0, 0, "t1");
        for (int i = 0; i < DEPTH; i++) begin
            if (i >= 1 && i <= 10) rd_chk(i, 1, f1[i - 1], "t1_entry");
            else rd_chk(i, 0, 0, "t1_entry");
        end
        chk("t1_err_ovf", err_ovf, 0);
        chk("t1_err_timeout", err_timeout, 0);
        chk("t1_err_range", err_range, 0);

        // Sweep 20..26, overflow at 25
        run_sweep(20, 26, 0, 0, "t2");
        rd_chk(24, 1, 46368, "t2_idx24");
        rd_chk(25, 1, 9489, "t2_idx25");
        rd_chk(26, 1, 55857, "t2_idx26");
        rd_chk(5, 0, 0, "t2_old_cleared");
        chk("t2_err_ovf", err_ovf, 1);

        // Calculator never completes
        run_sweep(3, 5, 1, 0, "t3");
        chk("t3_err_timeout", err_timeout, 1);
        chk("t3_err_ovf", err_ovf, 0);
        for (int i = 3; i <= 5; i++) rd_chk(i, 0, 0, "t3_entry");

        // Range error
        run_sweep(9, 4, 0, 0, "t4");
        chk("t4_err_range", err_range, 1);
        chk("t4_err_timeout", err_timeout, 0);

        // Reset mid-WAIT at index 6
        @(posedge clk); #1;
        first_idx = 5'd1;
        last_idx  = 5'd10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (calc_begin && calc_input_s == 5'd6) begin
                ok = 1;
                break;
            end
        end
        chk("t5_reach_idx6", ok, 1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_calc_reset_n", calc_reset_n, 0);
        chk("t5_calc_begin", calc_begin, 0);
        chk("t5_calc_input_s", calc_input_s, 0);
        chk("t5_rd_data", rd_data, 0);
        chk("t5_rd_valid", rd_valid, 0);
        chk("t5_err_ovf", err_ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) rd_chk(i, 0, 0, "t5_entry");

        // Single entry at top index with extra start while busy
        run_sweep(31, 31, 0, 1, "t6");
        rd_chk(31, 1, 35549, "t6_idx31");
        rd_chk(0, 0, 0, "t6_no_wrap");

        // Random sweeps
        for (int n = 0; n < 8; n++) begin
            f = $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) l = $urandom_range(0, 31);
            else l = f + $urandom_range(0, 31 - f);
            run_sweep(f, l, ($urandom_range(0, 5) == 0), $urandom_range(0, 1), "rand");
            repeat (4) @(posedge clk);
        end
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_watchdog: got no finish expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
